// File: rtl/bcd_updown_n_if.sv
// Handshake-free bus for the N-digit BCD up/down counter.
// Master drives count/load requests; slave returns the count and flags.
interface bcd_updown_n_if #(
  parameter int DIGITS = 4
);
  logic                  INC_N;
  logic                  DEC_N;
  logic                  LOAD;
  logic [4*DIGITS-1:0]   D;
  logic [4*DIGITS-1:0]   Q;
  logic                  CARRY;
  logic                  BORROW;
  logic                  ZERO;

  modport master (
    output INC_N, DEC_N, LOAD, D,
    input  Q, CARRY, BORROW, ZERO
  );

  modport slave (
    input  INC_N, DEC_N, LOAD, D,
    output Q, CARRY, BORROW, ZERO
  );
endinterface

// File: rtl/bcd_updown_n.sv
// N-digit synchronous BCD up/down counter, load, carry/borrow, zero flag.
// Define SATURATE_EN to hold at the limits instead of wrapping.
module bcd_updown_n #(
  parameter int DIGITS = 4
) (
  input  logic CLK,
  input  logic CLR,
  bcd_updown_n_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic inc_s1, inc_s2, inc_s3;
  logic dec_s1, dec_s2, dec_s3;
  logic inc_rise, dec_rise;
  logic up_ev, dn_ev;
  logic up_wrap, dn_wrap;
  logic [W-1:0] q_r, cnt_q, ld_v, nxt;
  logic carry_r, borrow_r, zero_r;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      inc_s1 <= 1'b1;
      inc_s2 <= 1'b1;
      inc_s3 <= 1'b1;
      dec_s1 <= 1'b1;
      dec_s2 <= 1'b1;
      dec_s3 <= 1'b1;
    end else begin
      inc_s1 <= bus.INC_N;
      inc_s2 <= inc_s1;
      inc_s3 <= inc_s2;
      dec_s1 <= bus.DEC_N;
      dec_s2 <= dec_s1;
      dec_s3 <= dec_s2;
    end
  end

  assign inc_rise = inc_s2 & ~inc_s3;
  assign dec_rise = dec_s2 & ~dec_s3;
  // A release counts only while the other input is idle and not also releasing.
  assign up_ev = inc_rise & dec_s2 & ~dec_rise;
  assign dn_ev = dec_rise & inc_s2 & ~inc_rise;

  always_comb begin : ripple
    logic cy;
    logic bw;
    cnt_q = q_r;
    ld_v  = '0;
    cy    = up_ev;
    bw    = dn_ev;
    for (int k = 0; k < DIGITS; k++) begin
      if (bus.D[4*k +: 4] > 4'd9) ld_v[4*k +: 4] = 4'd0;
      else ld_v[4*k +: 4] = bus.D[4*k +: 4];
      if (cy) begin
        if (q_r[4*k +: 4] == 4'd9) begin
          cnt_q[4*k +: 4] = 4'd0;
        end else begin
          cnt_q[4*k +: 4] = q_r[4*k +: 4] + 4'd1;
          cy = 1'b0;
        end
      end else if (bw) begin
        if (q_r[4*k +: 4] == 4'd0) begin
          cnt_q[4*k +: 4] = 4'd9;
        end else begin
          cnt_q[4*k +: 4] = q_r[4*k +: 4] - 4'd1;
          bw = 1'b0;
        end
      end
    end
    up_wrap = cy;
    dn_wrap = bw;
`ifdef SATURATE_EN
    if (cy | bw) cnt_q = q_r;
`endif
  end

  assign nxt = bus.LOAD ? ld_v : cnt_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      q_r      <= '0;
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
      zero_r   <= 1'b1;
    end else begin
      q_r      <= nxt;
      carry_r  <= ~bus.LOAD & up_wrap;
      borrow_r <= ~bus.LOAD & dn_wrap;
      zero_r   <= (nxt == '0);
    end
  end

  assign bus.Q      = q_r;
  assign bus.CARRY  = carry_r;
  assign bus.BORROW = borrow_r;
  assign bus.ZERO   = zero_r;
endmodule

// File: tb/tb_bcd_updown_n.sv
// Randomised bench for bcd_updown_n against an integer reference model.
// Build with SATURATE_EN defined to check the saturating variant.
module tb_bcd_updown_n;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;

  logic clk = 1'b0;
  logic clr = 1'b0;

  bcd_updown_n_if #(.DIGITS(DIGITS)) bus();

  bcd_updown_n #(.DIGITS(DIGITS)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_val    = 0;
  bit m_carry  = 1'b0;
  bit m_borrow = 1'b0;
  bit m_zero   = 1'b1;
  bit hi1 = 1'b1, hi2 = 1'b1, hi3 = 1'b1;
  bit hd1 = 1'b1, hd2 = 1'b1, hd3 = 1'b1;
  bit carry_seen = 1'b0;

  function automatic logic [W-1:0] to_bcd(int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_d(logic [W-1:0] d);
    int v;
    int dg;
    v = 0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dg = int'(d[4*k +: 4]);
      if (dg > 9) dg = 0;
      v = v * 10 + dg;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: pin samples are seen by the counter two edges later.
  always @(posedge clk) begin : model
    bit ir, dr, up, dn;
    if (!clr) begin
      m_val = 0; m_carry = 0; m_borrow = 0; m_zero = 1;
      hi1 = 1; hi2 = 1; hi3 = 1;
      hd1 = 1; hd2 = 1; hd3 = 1;
    end else begin
      ir = hi2 & !hi3;
      dr = hd2 & !hd3;
      up = ir & hd2 & !dr;
      dn = dr & hi2 & !ir;
      m_carry  = 0;
      m_borrow = 0;
      if (bus.LOAD) begin
        m_val = from_d(bus.D);
      end else if (up) begin
        if (m_val == MAXV) begin
          m_carry = 1;
`ifndef SATURATE_EN
          m_val = 0;
`endif
        end else begin
          m_val = m_val + 1;
        end
      end else if (dn) begin
        if (m_val == 0) begin
          m_borrow = 1;
`ifndef SATURATE_EN
          m_val = MAXV;
`endif
        end else begin
          m_val = m_val - 1;
        end
      end
      m_zero = (m_val == 0);
      hi3 = hi2; hi2 = hi1; hi1 = bus.INC_N;
      hd3 = hd2; hd2 = hd1; hd1 = bus.DEC_N;
    end
  end

  always @(negedge clk) begin
    check("q", bus.Q, to_bcd(m_val));
    check("carry", W'(bus.CARRY), W'(m_carry));
    check("borrow", W'(bus.BORROW), W'(m_borrow));
    check("zero", W'(bus.ZERO), W'(m_zero));
    if (bus.CARRY === 1'b1) carry_seen = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic pulse(input bit i, input bit d, input int lo, input int hi);
    if (i) bus.INC_N = 1'b0;
    if (d) bus.DEC_N = 1'b0;
    step(lo);
    bus.INC_N = 1'b1;
    bus.DEC_N = 1'b1;
    step(hi);
  endtask

  task automatic load(input logic [W-1:0] v);
    bus.LOAD = 1'b1;
    bus.D    = v;
    step(1);
    bus.LOAD = 1'b0;
  endtask

  initial begin
    int r;
    logic [W-1:0] dv;
    bus.INC_N = 1'b1;
    bus.DEC_N = 1'b1;
    bus.LOAD  = 1'b0;
    bus.D     = '0;
    step(2);
    check("rst_q", bus.Q, 16'h0000);
    check("rst_zero", W'(bus.ZERO), 16'h0001);
    clr = 1'b1;
    step(2);

    carry_seen = 1'b0;
    repeat (12) pulse(1'b1, 1'b0, 2, 2);
    step(3);
    check("inc12_q", bus.Q, 16'h0012);
    check("inc12_zero", W'(bus.ZERO), 16'h0000);
    check("inc12_nocarry", W'(carry_seen), 16'h0000);

    load(16'h0999);
    bus.INC_N = 1'b0;
    step(2);
    bus.INC_N = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("lat_before", bus.Q, 16'h0999);
    @(negedge clk);
    check("lat_at3", bus.Q, 16'h1000);
    check("lat_nocarry", W'(bus.CARRY), 16'h0000);
    #2;
    step(2);

    load(16'h9999);
    bus.INC_N = 1'b0;
    step(2);
    bus.INC_N = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
`ifdef SATURATE_EN
    check("up_lim_q", bus.Q, 16'h9999);
    check("up_lim_zero", W'(bus.ZERO), 16'h0000);
`else
    check("up_lim_q", bus.Q, 16'h0000);
    check("up_lim_zero", W'(bus.ZERO), 16'h0001);
`endif
    check("carry_hi", W'(bus.CARRY), 16'h0001);
    @(negedge clk);
    check("carry_lo", W'(bus.CARRY), 16'h0000);
    #2;
    step(2);

    load(16'h0000);
    bus.DEC_N = 1'b0;
    step(2);
    bus.DEC_N = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
`ifdef SATURATE_EN
    check("dn_lim_q", bus.Q, 16'h0000);
`else
    check("dn_lim_q", bus.Q, 16'h9999);
`endif
    check("borrow_hi", W'(bus.BORROW), 16'h0001);
    @(negedge clk);
    check("borrow_lo", W'(bus.BORROW), 16'h0000);
    #2;
    step(2);

    load(16'h1234);
    pulse(1'b1, 1'b1, 2, 4);
    check("both_q", bus.Q, 16'h1234);
    bus.DEC_N = 1'b0;
    bus.INC_N = 1'b0;
    step(2);
    bus.INC_N = 1'b1;
    step(4);
    check("inc_while_dec_q", bus.Q, 16'h1234);
    bus.DEC_N = 1'b1;
    step(4);
    check("dec_after_q", bus.Q, 16'h1233);

    load(16'h0100);
    bus.INC_N = 1'b0;
    step(2);
    bus.INC_N = 1'b1;
    step(2);
    load(16'h5A3F);
    check("load_prio_q", bus.Q, 16'h5030);
    step(3);
    check("load_nodefer_q", bus.Q, 16'h5030);

    bus.INC_N = 1'b0;
    step(2);
    bus.INC_N = 1'b1;
    step(1);
    clr = 1'b0;
    step(2);
    check("clr_q", bus.Q, 16'h0000);
    check("clr_zero", W'(bus.ZERO), 16'h0001);
    clr = 1'b1;
    step(6);
    check("clr_nospur_q", bus.Q, 16'h0000);

    repeat (250) begin
      r = $urandom_range(0, 11);
      if (r <= 3) begin
        pulse(1'b1, 1'b0, $urandom_range(2, 3), $urandom_range(2, 4));
      end else if (r <= 6) begin
        pulse(1'b0, 1'b1, $urandom_range(2, 3), $urandom_range(2, 4));
      end else if (r == 7) begin
        dv = W'($urandom);
        load(dv);
      end else if (r == 8) begin
        r = $urandom_range(0, 1);
        load(r == 0 ? 16'h9999 : 16'h0000);
      end else if (r == 9) begin
        pulse(1'b1, 1'b1, 2, $urandom_range(2, 4));
      end else if (r == 10) begin
        bus.INC_N = 1'b0;
        step(2);
        bus.INC_N = 1'b1;
        step($urandom_range(0, 2));
        dv = W'($urandom);
        load(dv);
        step(2);
      end else begin
        step($urandom_range(1, 3));
      end
    end
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
